sdram_init_refresh_ctrl: RTL and testbench

Sequences the SDRAM power-up procedure: 100 us of NOPs, PRECHARGE ALL, two AUTO REFRESH cycles, then LOAD MODE REGISTER. After that it schedules the periodic refresh. It owns the SDRAM command pins (cs/ras/cas/we/addr/ba) and lends them to the Wishbone-side access FSM through a grant. Refresh is inserted only when that FSM reports all banks idle.

---
 rtl/sdram_ctrl_pkg.sv | 42 ++++
 rtl/sdram_refresh_timer.sv | 58 +++++
 rtl/sdram_init_refresh_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_sdram_init_refresh_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sdram_ctrl_pkg.sv
// Shared SDRAM command encodings, controller states and default timing.
// Purely declarative; no latency or flow control of its own.
// Consumers import it with import sdram_ctrl_pkg::*.
package sdram_ctrl_pkg;

    // {cs, ras, cas, we}, all active low
    typedef enum logic [3:0] {
        INHIBIT      = 4'b1111,
        NOP          = 4'b0111,
        ACTIVE       = 4'b0011,
        READ         = 4'b0101,
        WRITE        = 4'b0100,
        PRECHARGE    = 4'b0010,
        AUTO_REFRESH = 4'b0001,
        LMR          = 4'b0000
    } sdram_cmd_t;

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_LMR,
        ST_IDLE,
        ST_REF_PRE,
        ST_REF_AR
    } ctrl_state_t;

    localparam int          DEF_INIT_CYCLES  = 5000;
    localparam int          DEF_T_RP         = 2;
    localparam int          DEF_T_RFC        = 7;
    localparam int          DEF_T_MRD        = 2;
    localparam int          DEF_REF_INTERVAL = 390;
    localparam int          DEF_ADDR_W       = 13;
    localparam logic [12:0] DEF_MODE_REG     = 13'h0032;
    localparam int          A10              = 10;

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh request generator with sticky overrun flag.
// Latency: request asserts the cycle after the counter reaches zero.
// No backpressure: an unserviced request at the next expiry is flagged as overrun.
module sdram_refresh_timer
    import sdram_ctrl_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_start,
    input  logic i_clear,
    output logic o_pending,
    output logic o_overrun
);

    localparam int              TW     = $clog2(REF_INTERVAL + 1);
    localparam logic [TW-1:0]   L_LOAD = TW'(REF_INTERVAL - 1);

    logic [TW-1:0] r_cnt;
    logic          r_run;
    logic          r_pending;
    logic          r_overrun;
    logic          w_expire;

    assign w_expire = r_run && (r_cnt == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_run     <= 1'b0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (i_start) begin
                r_run <= 1'b1;
                r_cnt <= L_LOAD;
            end else if (r_run) begin
                r_cnt <= w_expire ? L_LOAD : (r_cnt - TW'(1));
            end

            // A fresh expiry beats a simultaneous clear: the new request survives.
            if (w_expire) begin
                r_pending <= 1'b1;
            end else if (i_clear) begin
                r_pending <= 1'b0;
            end

            if (w_expire && r_pending && !i_clear) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/sdram_init_refresh_ctrl.sv
// SDRAM power-up sequencer and refresh scheduler owning the command pins.
// Latency: every pin value is registered, one cycle after the deciding state.
// Backpressure: refresh waits indefinitely for user_idle while the grant is kept.
module sdram_init_refresh_ctrl
    import sdram_ctrl_pkg::*;
#(
    parameter int                INIT_CYCLES  = DEF_INIT_CYCLES,
    parameter int                T_RP         = DEF_T_RP,
    parameter int                T_RFC        = DEF_T_RFC,
    parameter int                T_MRD        = DEF_T_MRD,
    parameter int                REF_INTERVAL = DEF_REF_INTERVAL,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] MODE_REG     = ADDR_W'(DEF_MODE_REG)
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              cs,
    output logic              ras,
    output logic              cas,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ba,
    output logic              init_done,
    output logic              user_gnt,
    input  logic              user_idle,
    input  logic [3:0]        user_cmd,
    input  logic [ADDR_W-1:0] user_addr,
    input  logic [1:0]        user_ba,
    output logic              ref_busy,
    output logic              ref_overrun
);

    localparam int CNT_MAX = max_of(max_of(INIT_CYCLES, T_RP), max_of(T_RFC, T_MRD));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Init steps are spaced command-to-command; refresh keeps a full extra NOP margin.
    localparam logic [CNT_W-1:0] L_INIT_LAST = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_RP_INIT   = CNT_W'(T_RP - 1);
    localparam logic [CNT_W-1:0] L_RFC_INIT  = CNT_W'(T_RFC - 1);
    localparam logic [CNT_W-1:0] L_MRD_INIT  = CNT_W'(T_MRD - 1);
    localparam logic [CNT_W-1:0] L_RP_REF    = CNT_W'(T_RP);
    localparam logic [CNT_W-1:0] L_RFC_REF   = CNT_W'(T_RFC);

    ctrl_state_t       r_state;
    logic [CNT_W-1:0]  r_cnt;
    sdram_cmd_t        r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_ba;
    logic              r_init_done;

    ctrl_state_t       w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    sdram_cmd_t        w_cmd_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [1:0]        w_ba_nxt;
    logic              w_ref_done;
    logic              w_timer_start;
    logic              w_pending;
    logic              w_overrun;
    logic              w_gnt;

    assign w_gnt         = (r_state == ST_IDLE) && r_init_done;
    assign w_timer_start = (r_state == ST_IDLE) && !r_init_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_cmd_nxt   = NOP;
        w_addr_nxt  = '0;
        w_ba_nxt    = '0;
        w_ref_done  = 1'b0;
        case (r_state)
            ST_INIT_WAIT: begin
                if (r_cnt == L_INIT_LAST) begin
                    w_state_nxt = ST_INIT_PRE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_INIT_PRE: begin
                if (r_cnt == '0) begin
                    w_cmd_nxt       = PRECHARGE;
                    w_addr_nxt[A10] = 1'b1;
                end
                if (r_cnt == L_RP_INIT) begin
                    w_state_nxt = ST_INIT_REF1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_INIT_REF1: begin
                if (r_cnt == '0) w_cmd_nxt = AUTO_REFRESH;
                if (r_cnt == L_RFC_INIT) begin
                    w_state_nxt = ST_INIT_REF2;
                    w_cnt_nxt   = '0;
                end
            end
            ST_INIT_REF2: begin
                if (r_cnt == '0) w_cmd_nxt = AUTO_REFRESH;
                if (r_cnt == L_RFC_INIT) begin
                    w_state_nxt = ST_INIT_LMR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_INIT_LMR: begin
                if (r_cnt == '0) begin
                    w_cmd_nxt  = LMR;
                    w_addr_nxt = MODE_REG;
                end
                if (r_cnt == L_MRD_INIT) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_gnt) begin
                    w_cmd_nxt  = sdram_cmd_t'(user_cmd);
                    w_addr_nxt = user_addr;
                    w_ba_nxt   = user_ba;
                end
                if (r_init_done && w_pending && user_idle) begin
                    w_state_nxt = ST_REF_PRE;
                end
            end
            ST_REF_PRE: begin
                if (r_cnt == '0) begin
                    w_cmd_nxt       = PRECHARGE;
                    w_addr_nxt[A10] = 1'b1;
                end
                if (r_cnt == L_RP_REF) begin
                    w_state_nxt = ST_REF_AR;
                    w_cnt_nxt   = '0;
                end
            end
            ST_REF_AR: begin
                if (r_cnt == '0) w_cmd_nxt = AUTO_REFRESH;
                if (r_cnt == L_RFC_REF) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_ref_done  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_INIT_WAIT;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_INIT_WAIT;
            r_cnt       <= '0;
            r_cmd       <= INHIBIT;
            r_addr      <= '0;
            r_ba        <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cmd       <= w_cmd_nxt;
            r_addr      <= w_addr_nxt;
            r_ba        <= w_ba_nxt;
            r_init_done <= r_init_done || (r_state == ST_IDLE);
        end
    end

    sdram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_start   (w_timer_start),
        .i_clear   (w_ref_done),
        .o_pending (w_pending),
        .o_overrun (w_overrun)
    );

    assign cs          = r_cmd[3];
    assign ras         = r_cmd[2];
    assign cas         = r_cmd[1];
    assign we          = r_cmd[0];
    assign addr        = r_addr;
    assign ba          = r_ba;
    assign init_done   = r_init_done;
    assign user_gnt    = w_gnt;
    assign ref_busy    = (r_state == ST_REF_PRE) || (r_state == ST_REF_AR);
    assign ref_overrun = w_overrun;

endmodule

// File: tb/tb_sdram_init_refresh_ctrl.sv
// Directed bench for the SDRAM init/refresh controller with hand-derived cycle numbers.
// Cycle k means the pin values visible just after the k-th clk edge following reset release (k from 0).
module tb_sdram_init_refresh_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs, ras, cas, we;
    logic [12:0] addr;
    logic [1:0]  ba;
    logic        init_done, user_gnt, ref_busy, ref_overrun;
    logic        user_idle;
    logic [3:0]  user_cmd;
    logic [12:0] user_addr;
    logic [1:0]  user_ba;

    int cyc;
    int n_vec = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    sdram_init_refresh_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cs          (cs),
        .ras         (ras),
        .cas         (cas),
        .we          (we),
        .addr        (addr),
        .ba          (ba),
        .init_done   (init_done),
        .user_gnt    (user_gnt),
        .user_idle   (user_idle),
        .user_cmd    (user_cmd),
        .user_addr   (user_addr),
        .user_ba     (user_ba),
        .ref_busy    (ref_busy),
        .ref_overrun (ref_overrun)
    );

    wire [3:0] pins = {cs, ras, cas, we};

    task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    task automatic step_to(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        cyc     = -1;
    endtask

    task automatic init_check(input string tag);
        int         nbad;
        logic [3:0] exp_cmd;
        nbad      = 0;
        user_cmd  = 4'b0011;
        user_addr = 13'h1fff;
        user_ba   = 2'd3;
        for (int k = 0; k <= 5018; k++) begin
            step_to(k);
            case (k)
                5000:       exp_cmd = 4'b0010;
                5002, 5009: exp_cmd = 4'b0001;
                5016:       exp_cmd = 4'b0000;
                default:    exp_cmd = 4'b0111;
            endcase
            if (pins !== exp_cmd) begin
                if (nbad == 0) $display("first bad init cycle %0d pins %b", k, pins);
                nbad++;
            end
            if (k == 100)  chk_vec({tag, "_gnt_during_init"}, 32'(user_gnt), 32'd0);
            if (k == 5000) chk_vec({tag, "_pre_a10"}, 32'(addr[10]), 32'd1);
            if (k == 5016) chk_vec({tag, "_lmr_addr"}, 32'(addr), 32'h0032);
            if (k == 5016) chk_vec({tag, "_lmr_ba"}, 32'(ba), 32'd0);
            if (k == 5017) chk_vec({tag, "_done_early"}, 32'({init_done, user_gnt}), 32'd0);
            if (k == 5018) chk_vec({tag, "_done_gnt"}, 32'({init_done, user_gnt}), 32'b11);
        end
        chk_vec({tag, "_cmd_seq_bad"}, 32'(nbad), 32'd0);
        user_cmd  = 4'b0111;
        user_addr = '0;
        user_ba   = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int         nbad;
        int         nbusy;
        int         ngap;
        logic [3:0] exp_cmd;
        logic       exp_gnt;

        user_idle = 1'b1;
        user_cmd  = 4'b0011;
        user_addr = 13'h0555;
        user_ba   = 2'd1;
        cyc       = -1;

        // Reset state with busy user inputs.
        repeat (2) @(posedge clk);
        #1;
        chk_vec("rst_pins", 32'(pins), 32'hf);
        chk_vec("rst_addr_ba", 32'({addr, ba}), 32'd0);
        chk_vec("rst_flags", 32'({init_done, user_gnt, ref_busy, ref_overrun}), 32'd0);
        release_reset();

        init_check("run1");

        // Grant pass-through, one cycle latency.
        step_to(5020);
        user_cmd = 4'b0011; user_addr = 13'h0123; user_ba = 2'd2;
        step_to(5021);
        chk_vec("pass_active_cmd", 32'(pins), 32'h3);
        chk_vec("pass_active_addr", 32'(addr), 32'h0123);
        chk_vec("pass_active_ba", 32'(ba), 32'd2);
        user_cmd = 4'b0101; user_addr = 13'h1fff; user_ba = 2'd1;
        step_to(5022);
        chk_vec("pass_read", 32'({pins, addr, ba}), {4'b0101, 13'h1fff, 2'd1});
        user_cmd = 4'b0111; user_addr = '0; user_ba = '0;

        // First refresh: timer loads at 5018, expires at edge 5408, FSM leaves IDLE at 5409.
        nbad  = 0;
        nbusy = 0;
        for (int k = 5400; k <= 5422; k++) begin
            step_to(k);
            exp_cmd = (k == 5410) ? 4'b0010 : (k == 5413) ? 4'b0001 : 4'b0111;
            exp_gnt = !(k >= 5409 && k <= 5419);
            if (pins !== exp_cmd || user_gnt !== exp_gnt || ref_busy !== !exp_gnt) begin
                if (nbad == 0) $display("first bad refresh cycle %0d pins %b gnt %b busy %b", k, pins, user_gnt, ref_busy);
                nbad++;
            end
            if (ref_busy === 1'b1) nbusy++;
            if (k == 5410) chk_vec("ref_pre_a10", 32'(addr[10]), 32'd1);
        end
        chk_vec("ref_seq_bad", 32'(nbad), 32'd0);
        chk_vec("ref_busy_len", 32'(nbusy), 32'd11);
        chk_vec("ref_no_overrun", 32'(ref_overrun), 32'd0);

        // Request at 5798 waits for user_idle; release it so refresh ends exactly at next expiry 6188.
        user_idle = 1'b0;
        step_to(6176);
        chk_vec("wait_keeps_gnt", 32'({user_gnt, ref_busy}), 32'b10);
        user_idle = 1'b1;
        step_to(6177);
        chk_vec("late_ref_start", 32'({user_gnt, ref_busy}), 32'b01);
        step_to(6188);
        chk_vec("coincide_back_idle", 32'({user_gnt, ref_busy}), 32'b10);
        chk_vec("coincide_no_overrun", 32'(ref_overrun), 32'd0);
        step_to(6189);
        chk_vec("coincide_new_req_wins", 32'(ref_busy), 32'd1);

        // Asynchronous reset mid-refresh.
        step_to(6190);
        #4;
        reset_n = 1'b0;
        #1;
        chk_vec("rst_mid_ref_pins", 32'(pins), 32'hf);
        chk_vec("rst_mid_ref_busy", 32'({ref_busy, init_done}), 32'd0);
        repeat (2) @(posedge clk);
        release_reset();

        // Asynchronous reset mid-init, then full restart.
        step_to(5005);
        #4;
        reset_n = 1'b0;
        #1;
        chk_vec("rst_mid_init_pins", 32'(pins), 32'hf);
        repeat (2) @(posedge clk);
        user_idle = 1'b0;
        release_reset();
        init_check("run2");

        // user_idle held low: requests at 5408 and 5798, overrun at the second.
        nbusy = 0;
        ngap  = 0;
        for (int k = 5019; k <= 5798; k++) begin
            step_to(k);
            if (ref_busy === 1'b1) nbusy++;
            if (user_gnt !== 1'b1) ngap++;
            if (k == 5797) chk_vec("overrun_before", 32'(ref_overrun), 32'd0);
        end
        chk_vec("overrun_set", 32'(ref_overrun), 32'd1);
        chk_vec("no_ref_while_busy_user", 32'(nbusy), 32'd0);
        chk_vec("gnt_held_while_pending", 32'(ngap), 32'd0);
        step_to(5800);
        user_idle = 1'b1;
        step_to(5801);
        chk_vec("ref_after_idle", 32'({user_gnt, ref_busy}), 32'b01);
        step_to(5802);
        chk_vec("ref_after_idle_pre", 32'(pins), 32'h2);
        step_to(5812);
        chk_vec("ref_after_idle_done", 32'({user_gnt, ref_busy}), 32'b10);
        chk_vec("overrun_sticky", 32'(ref_overrun), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
